// File: rtl/bayer_demosaic_pkg.sv
// Shared constants for the Bayer demosaic: CFA phase encodings and site-type classification.
package bayer_demosaic_pkg;

  localparam logic [1:0] PAT_RGGB = 2'd0;
  localparam logic [1:0] PAT_GRBG = 2'd1;
  localparam logic [1:0] PAT_GBRG = 2'd2;
  localparam logic [1:0] PAT_BGGR = 2'd3;

  localparam logic [1:0] SITE_R  = 2'b00;
  localparam logic [1:0] SITE_GR = 2'b01;
  localparam logic [1:0] SITE_GB = 2'b10;
  localparam logic [1:0] SITE_B  = 2'b11;

  // Row parity picks R/B row, column parity picks G vs R/B, both offset by the phase.
  function automatic logic [1:0] site_type(input logic [1:0] pat, input logic cx0, input logic cy0);
    return {cy0 ^ pat[1], cx0 ^ pat[0]};
  endfunction

endpackage

// File: rtl/window_3x3_lb.sv
// 3x3 sliding window: two line buffers hold the previous two rows, shift registers hold
// the previous two columns. Window k = row*3+col, row 0 oldest, col 0 leftmost.
module window_3x3_lb #(
  parameter int DW    = 8,
  parameter int MAX_W = 2048
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DW-1:0]              in_data,
  input  logic [$clog2(MAX_W)-1:0]   in_col,
  output logic                       win_valid,
  input  logic                       win_ready,
  output logic [9*DW-1:0]            win
);

  logic [DW-1:0] lb1 [MAX_W];
  logic [DW-1:0] lb2 [MAX_W];
  logic [2:0][DW-1:0] fresh, sr1, sr2;
  logic fire;

  assign in_ready  = win_ready;
  assign win_valid = in_valid;
  assign fire      = in_valid & win_ready;

  assign fresh[0] = lb2[in_col];
  assign fresh[1] = lb1[in_col];
  assign fresh[2] = in_data;

  for (genvar r = 0; r < 3; r++) begin : g_row
    assign win[(r*3+0)*DW +: DW] = sr2[r];
    assign win[(r*3+1)*DW +: DW] = sr1[r];
    assign win[(r*3+2)*DW +: DW] = fresh[r];
  end

  always_ff @(posedge clk) begin
    if (fire) begin
      lb2[in_col] <= lb1[in_col];
      lb1[in_col] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr1 <= '0;
      sr2 <= '0;
    end else if (fire) begin
      sr2 <= sr1;
      sr1 <= fresh;
    end
  end

endmodule

// File: rtl/bayer_demosaic.sv
// Bayer-to-RGB bilinear demosaic with runtime CFA phase and crop window.
// Define BAYER_DEMOSAIC_ROUND_EN for round-half-up averages; default truncates.
module bayer_demosaic
  import bayer_demosaic_pkg::*;
#(
  parameter int DW    = 8,
  parameter int CW    = 11,
  parameter int MAX_W = 2048
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CW-1:0]   src_width,
  input  logic [CW-1:0]   src_height,
  input  logic [1:0]      bayer_pat,
  input  logic [CW-1:0]   crop_x,
  input  logic [CW-1:0]   crop_y,
  input  logic [CW-1:0]   dst_width,
  input  logic [CW-1:0]   dst_height,
  input  logic            src_valid,
  output logic            src_ready,
  input  logic [DW-1:0]   src_data,
  output logic            dst_valid,
  input  logic            dst_ready,
  output logic [3*DW-1:0] dst_data,
  output logic            dst_start,
  output logic            dst_line_last,
  output logic            dst_last
);

  localparam int AW = $clog2(MAX_W);

  logic [CW-1:0] cnt_w, cnt_h;
  logic [CW-1:0] c_src_w, c_src_h, c_crop_x, c_crop_y, c_dst_w, c_dst_h;
  logic [1:0]    c_pat;
  logic          in_ready, win_valid, fire, at_origin;
  logic [9*DW-1:0] win;
  logic [AW-1:0] col;
  logic [CW-1:0] eff_w, eff_h;

  assign in_ready  = dst_ready | ~dst_valid;
  assign fire      = win_valid & in_ready;
  assign at_origin = (cnt_w == '0) && (cnt_h == '0);
  assign col       = AW'(cnt_w);

  window_3x3_lb #(.DW(DW), .MAX_W(MAX_W)) u_win (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (src_valid),
    .in_ready  (src_ready),
    .in_data   (src_data),
    .in_col    (col),
    .win_valid (win_valid),
    .win_ready (in_ready),
    .win       (win)
  );

  // Config is latched on the (0,0) beat, so that beat's own wrap checks use the live ports.
  assign eff_w = at_origin ? src_width  : c_src_w;
  assign eff_h = at_origin ? src_height : c_src_h;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_w    <= '0;
      cnt_h    <= '0;
      c_src_w  <= '0;
      c_src_h  <= '0;
      c_crop_x <= '0;
      c_crop_y <= '0;
      c_dst_w  <= '0;
      c_dst_h  <= '0;
      c_pat    <= '0;
    end else if (fire) begin
      if (at_origin) begin
        c_src_w  <= src_width;
        c_src_h  <= src_height;
        c_crop_x <= crop_x;
        c_crop_y <= crop_y;
        c_dst_w  <= dst_width;
        c_dst_h  <= dst_height;
        c_pat    <= bayer_pat;
      end
      if (cnt_w == eff_w - 1'b1) begin
        cnt_w <= '0;
        cnt_h <= (cnt_h == eff_h - 1'b1) ? '0 : cnt_h + 1'b1;
      end else begin
        cnt_w <= cnt_w + 1'b1;
      end
    end
  end

  // Centre is one up/left of the incoming pixel; at column/row 0 it wraps to all-ones
  // in CW+1 bits, which always falls outside the crop window.
  logic [CW:0] cx, cy, x_end, y_end;
  logic        in_win, is_x_first, is_y_first, is_x_last, is_y_last;
  logic [1:0]  site;

  assign cx    = {1'b0, cnt_w} - 1'b1;
  assign cy    = {1'b0, cnt_h} - 1'b1;
  assign x_end = {1'b0, c_crop_x} + {1'b0, c_dst_w};
  assign y_end = {1'b0, c_crop_y} + {1'b0, c_dst_h};

  assign in_win     = (cx >= {1'b0, c_crop_x}) && (cx < x_end) &&
                      (cy >= {1'b0, c_crop_y}) && (cy < y_end);
  assign is_x_first = (cx == {1'b0, c_crop_x});
  assign is_y_first = (cy == {1'b0, c_crop_y});
  assign is_x_last  = (cx == x_end - 1'b1);
  assign is_y_last  = (cy == y_end - 1'b1);
  assign site       = site_type(c_pat, cx[0], cy[0]);

  function automatic logic [DW-1:0] avg2(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW+1:0] s;
    s = {2'b0, a} + {2'b0, b};
`ifdef BAYER_DEMOSAIC_ROUND_EN
    s = s + (DW+2)'(1);
`endif
    return DW'(s >> 1);
  endfunction

  function automatic logic [DW-1:0] avg4(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                         input logic [DW-1:0] c, input logic [DW-1:0] d);
    logic [DW+1:0] s;
    s = {2'b0, a} + {2'b0, b} + {2'b0, c} + {2'b0, d};
`ifdef BAYER_DEMOSAIC_ROUND_EN
    s = s + (DW+2)'(2);
`endif
    return DW'(s >> 2);
  endfunction

  logic [DW-1:0] p_nw, p_n, p_ne, p_w, p_c, p_e, p_sw, p_s, p_se;
  logic [DW-1:0] r_v, g_v, b_v;

  assign p_nw = win[0*DW +: DW];
  assign p_n  = win[1*DW +: DW];
  assign p_ne = win[2*DW +: DW];
  assign p_w  = win[3*DW +: DW];
  assign p_c  = win[4*DW +: DW];
  assign p_e  = win[5*DW +: DW];
  assign p_sw = win[6*DW +: DW];
  assign p_s  = win[7*DW +: DW];
  assign p_se = win[8*DW +: DW];

  always_comb begin
    r_v = p_c;
    g_v = p_c;
    b_v = p_c;
    case (site)
      SITE_R: begin
        g_v = avg4(p_n, p_s, p_w, p_e);
        b_v = avg4(p_nw, p_ne, p_sw, p_se);
      end
      SITE_B: begin
        g_v = avg4(p_n, p_s, p_w, p_e);
        r_v = avg4(p_nw, p_ne, p_sw, p_se);
      end
      SITE_GR: begin
        r_v = avg2(p_w, p_e);
        b_v = avg2(p_n, p_s);
      end
      default: begin
        b_v = avg2(p_w, p_e);
        r_v = avg2(p_n, p_s);
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dst_valid     <= 1'b0;
      dst_data      <= '0;
      dst_start     <= 1'b0;
      dst_line_last <= 1'b0;
      dst_last      <= 1'b0;
    end else if (fire) begin
      dst_valid     <= in_win;
      dst_data      <= {r_v, g_v, b_v};
      dst_start     <= in_win & is_x_first & is_y_first;
      dst_line_last <= in_win & is_x_last;
      dst_last      <= in_win & is_x_last & is_y_last;
    end else if (dst_ready) begin
      dst_valid     <= 1'b0;
      dst_start     <= 1'b0;
      dst_line_last <= 1'b0;
      dst_last      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bayer_demosaic.sv
// Scoreboard bench for bayer_demosaic: a neighbourhood-average reference model pushes
// expected pixels per frame; a negedge monitor pops and compares on each output handshake.
module tb_bayer_demosaic;

  logic        clk, rst;
  logic [10:0] src_width, src_height, crop_x, crop_y, dst_width, dst_height;
  logic [1:0]  bayer_pat;
  logic        src_valid, src_ready, dst_valid, dst_ready;
  logic [7:0]  src_data;
  logic [23:0] dst_data;
  logic        dst_start, dst_line_last, dst_last;

  bayer_demosaic dut (
    .clk(clk), .rst(rst), .src_width(src_width), .src_height(src_height),
    .bayer_pat(bayer_pat), .crop_x(crop_x), .crop_y(crop_y),
    .dst_width(dst_width), .dst_height(dst_height),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
    .dst_valid(dst_valid), .dst_ready(dst_ready), .dst_data(dst_data),
    .dst_start(dst_start), .dst_line_last(dst_line_last), .dst_last(dst_last)
  );

  typedef struct packed {
    logic [23:0] data;
    logic        s;
    logic        ll;
    logic        l;
  } exp_t;

  exp_t q[$];
  int   errors = 0, checks = 0, popped = 0;
  logic stall = 1'b0;
  logic [7:0] img [0:15][0:15];

  // colour at each 2x2 phase position: 0 R, 1 G, 2 B
  localparam int TBL [16] = '{0,1,1,2, 1,0,2,1, 1,2,0,1, 2,1,1,0};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    dst_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      dst_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  function automatic int colour_at(input int pat, input int y, input int x);
    return TBL[pat*4 + (y%2)*2 + (x%2)];
  endfunction

  // Bilinear: own sample if the site carries the channel, else mean of same-colour neighbours.
  function automatic logic [7:0] chan(input int pat, input int y, input int x, input int ch);
    int s, n;
    s = 0; n = 0;
    if (colour_at(pat, y, x) == ch) return img[y][x];
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        if (!(dy == 0 && dx == 0) && colour_at(pat, y+dy, x+dx) == ch) begin
          s += int'(img[y+dy][x+dx]);
          n++;
        end
`ifdef BAYER_DEMOSAIC_ROUND_EN
    s += n / 2;
`endif
    return 8'(s / n);
  endfunction

  task automatic push_expect();
    exp_t e;
    int x0, y0, x1, y1, p;
    x0 = int'(crop_x); y0 = int'(crop_y);
    x1 = x0 + int'(dst_width) - 1; y1 = y0 + int'(dst_height) - 1;
    p = int'(bayer_pat);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++) begin
        e.data = {chan(p, y, x, 0), chan(p, y, x, 1), chan(p, y, x, 2)};
        e.s    = (y == y0) && (x == x0);
        e.ll   = (x == x1);
        e.l    = (x == x1) && (y == y1);
        q.push_back(e);
      end
  endtask

  task automatic set_cfg(input int w, input int h, input int p, input int cx, input int cy,
                         input int dw, input int dh);
    src_width = 11'(w); src_height = 11'(h); bayer_pat = 2'(p);
    crop_x = 11'(cx); crop_y = 11'(cy); dst_width = 11'(dw); dst_height = 11'(dh);
  endtask

  task automatic fill_const(input int v);
    for (int y = 0; y < 16; y++) for (int x = 0; x < 16; x++) img[y][x] = 8'(v);
  endtask

  task automatic fill_mosaic(input int p);
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++)
        case (colour_at(p, y, x))
          0:       img[y][x] = 8'd200;
          1:       img[y][x] = 8'd100;
          default: img[y][x] = 8'd50;
        endcase
  endtask

  task automatic fill_random();
    for (int y = 0; y < 16; y++) for (int x = 0; x < 16; x++) img[y][x] = 8'($urandom);
  endtask

  task automatic send_beat(input logic [7:0] d);
    int t;
    t = 0;
    src_valid = 1'b1;
    src_data  = d;
    forever begin
      @(negedge clk);
      if (src_ready) break;
      t++;
      if (t > 1000) begin
        checks++; errors++;
        $display("FAIL src_ready_timeout: got ready=0 for 1000 cycles, want 1");
        break;
      end
    end
    @(posedge clk); #1;
    src_valid = 1'b0;
  endtask

  // abort_at / change_at are beat indices (-1 = never)
  task automatic send_frame(input int abort_at, input int change_at);
    int w, h, idx;
    w = int'(src_width); h = int'(src_height);
    push_expect();
    idx = 0;
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) begin
        if (idx == abort_at) return;
        if (idx == change_at) begin
          crop_x = 11'd2;
          dst_width = 11'd5;
        end
        if (stall && $urandom_range(0, 1) == 1) begin
          src_valid = 1'b0;
          @(posedge clk); #1;
        end
        send_beat(img[y][x]);
        idx++;
      end
  endtask

  task automatic drain(input string name, input int want);
    int t;
    t = 0;
    while (q.size() > 0 && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0 || popped != want) begin
      errors++;
      $display("FAIL %s_count: got %0d pixels (%0d still expected), want %0d", name, popped, q.size(), want);
    end
    popped = 0;
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (dst_valid !== 1'b0 || dst_data !== 24'h0 || dst_start !== 1'b0 ||
        dst_line_last !== 1'b0 || dst_last !== 1'b0) begin
      errors++;
      $display("FAIL %s: got valid=%b data=%h start=%b line_last=%b last=%b, want all 0",
               name, dst_valid, dst_data, dst_start, dst_line_last, dst_last);
    end
  endtask

  // Monitor: compare on handshake; also require held output to stay unchanged while stalled.
  initial begin
    exp_t cur, prev, e;
    logic held;
    held = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
        continue;
      end
      cur = {dst_data, dst_start, dst_line_last, dst_last};
      if (held) begin
        checks++;
        if (!dst_valid || cur != prev) begin
          errors++;
          $display("FAIL hold_stable: got valid=%b out=%h, want valid=1 out=%h", dst_valid, cur, prev);
        end
      end
      if (dst_valid && dst_ready) begin
        checks++;
        popped++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pixel: got out=%h, want no output", cur);
        end else begin
          e = q.pop_front();
          if (cur != e) begin
            errors++;
            $display("FAIL pixel: got rgb=%h s/ll/l=%b%b%b, want rgb=%h s/ll/l=%b%b%b",
                     cur.data, cur.s, cur.ll, cur.l, e.data, e.s, e.ll, e.l);
          end
        end
      end
      held = dst_valid && !dst_ready;
      prev = cur;
    end
  end

  initial begin
    int w, h, cx, cy;
    rst = 1'b1;
    src_valid = 1'b0;
    src_data = '0;
    set_cfg(8, 6, 2, 1, 1, 6, 4);
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset_state");
    rst = 1'b0;

    // common setup, constant 100
    fill_const(100);
    send_frame(-1, -1);
    drain("const_frame", 24);

    // pattern sweep with a mosaic matched to each phase
    for (int p = 0; p < 4; p++) begin
      set_cfg(8, 6, p, 1, 1, 6, 4);
      fill_mosaic(p);
      send_frame(-1, -1);
      drain("pattern_sweep", 24);
    end

    // rounding case around R site (2,2)
    set_cfg(8, 6, 0, 1, 1, 6, 4);
    fill_random();
    img[1][2] = 8'd1; img[3][2] = 8'd2; img[2][1] = 8'd2; img[2][3] = 8'd2;
    send_frame(-1, -1);
    drain("rounding", 24);

    // backpressure on common setup, then random geometry
    stall = 1'b1;
    set_cfg(8, 6, 2, 1, 1, 6, 4);
    fill_const(100);
    send_frame(-1, -1);
    drain("stall_const", 24);
    for (int i = 0; i < 6; i++) begin
      w  = $urandom_range(3, 16);
      h  = $urandom_range(3, 10);
      cx = $urandom_range(1, w - 2);
      cy = $urandom_range(1, h - 2);
      set_cfg(w, h, $urandom_range(0, 3), cx, cy,
              $urandom_range(1, w - 1 - cx), $urandom_range(1, h - 1 - cy));
      fill_random();
      send_frame(-1, -1);
      drain("stall_random", int'(dst_width) * int'(dst_height));
    end
    stall = 1'b0;

    // crop change mid-frame takes effect on the next frame only
    set_cfg(8, 6, 2, 1, 1, 6, 4);
    fill_random();
    send_frame(-1, 10);
    send_frame(-1, -1);
    drain("midframe_crop", 24 + 20);

    // reset mid-frame
    set_cfg(8, 6, 2, 1, 1, 6, 4);
    fill_random();
    send_frame(20, -1);
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    check_idle("midframe_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    popped = 0;
    send_frame(-1, -1);
    drain("after_reset", 24);

    // back-to-back frames
    fill_random();
    send_frame(-1, -1);
    fill_random();
    send_frame(-1, -1);
    drain("back_to_back", 48);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
